// File: rtl/upcnt_cmd_arbiter.sv
// upcnt_cmd_arbiter: merges front-panel buttons and UART command bytes into
// the run/clear controls of the 0-9999 up-counter (STOP/RUN/CLEAR FSM).
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   i_btn_run_stop debounced run/stop button (level)
//   i_btn_clear    debounced clear button (level)
//   i_rx_data      received UART byte, valid with i_rx_done
//   i_rx_done      one-cycle strobe, byte received
//   i_tx_busy      UART transmitter busy
//   o_run_on       counter enable (state RUN)
//   o_clr_on       counter clear (state CLEAR)
//   o_overrun      one-cycle pulse, pending UART byte overwritten
//   o_tx_data      echo byte
//   o_tx_start     one-cycle transmit request
//
// Build option: define UPCNT_CMD_ECHO_EN to echo consumed UART bytes
// (known commands uppercased, unknown bytes as '?'); otherwise tx is tied 0.

module upcnt_cmd_arbiter #(
  parameter logic [7:0]  CMD_RUN   = 8'h72,
  parameter logic [7:0]  CMD_STOP  = 8'h73,
  parameter logic [7:0]  CMD_CLEAR = 8'h63,
  parameter int unsigned CLR_HOLD  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_run_stop,
  input  logic       i_btn_clear,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  input  logic       i_tx_busy,
  output logic       o_run_on,
  output logic       o_clr_on,
  output logic       o_overrun,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start
);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_CLEAR
  } state_t;

  localparam logic [3:0] CLR_LAST = 4'(CLR_HOLD - 1);

  state_t     state;
  state_t     state_nx;

  logic       run_d;
  logic       clr_d;
  logic       ev_run;
  logic       ev_clr;
  logic       ev_btn;

  logic       pend_vld;
  logic [7:0] pend_data;
  logic       pend_take;
  logic [7:0] pend_lc;
  logic       is_run;
  logic       is_stop;
  logic       is_clr;

  logic       do_run;
  logic       do_stop;
  logic       do_clr;

  logic [3:0] clr_cnt;
  logic       clr_last;

  // ---------------- button edge detect ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_d <= 1'b0;
      clr_d <= 1'b0;
    end else begin
      run_d <= i_btn_run_stop;
      clr_d <= i_btn_clear;
    end
  end

  assign ev_run = i_btn_run_stop & ~run_d;
  assign ev_clr = i_btn_clear & ~clr_d;
  assign ev_btn = ev_run | ev_clr;

  // ---------------- pending UART byte ----------------
  // Buttons win the cycle; pending waits for a cycle with no button event.
  assign pend_take = pend_vld & ~ev_btn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_vld  <= 1'b0;
      pend_data <= 8'h00;
      o_overrun <= 1'b0;
    end else begin
      // An entry consumed this cycle is not overwritten, so no overrun.
      o_overrun <= i_rx_done & pend_vld & ~pend_take;
      if (i_rx_done) begin
        pend_vld  <= 1'b1;
        pend_data <= i_rx_data;
      end else if (pend_take) begin
        pend_vld  <= 1'b0;
      end
    end
  end

  // Setting bit 5 folds ASCII upper case onto lower case.
  assign pend_lc = pend_data | 8'h20;
  assign is_run  = pend_take & (pend_lc == CMD_RUN);
  assign is_stop = pend_take & (pend_lc == CMD_STOP);
  assign is_clr  = pend_take & (pend_lc == CMD_CLEAR);

  // Simultaneous button rises: clear wins, run/stop is dropped.
  assign do_clr  = ev_clr | is_clr;
  assign do_run  = (ev_run & ~ev_clr) | is_run;
  assign do_stop = is_stop;

  // ---------------- clear hold counter ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt <= 4'd0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 4'd1;
    end else begin
      clr_cnt <= 4'd0;
    end
  end

  assign clr_last = (clr_cnt == CLR_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_STOP;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_STOP: begin
        if (do_clr) begin
          state_nx = ST_CLEAR;
        end else if (do_run) begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        // A clear while running is consumed and ignored.
        if (do_run || do_stop) begin
          state_nx = ST_STOP;
        end
      end
      ST_CLEAR: begin
        if (clr_last) begin
          state_nx = ST_STOP;
        end
      end
      default: state_nx = ST_STOP;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_run_on = 1'b0;
    o_clr_on = 1'b0;
    unique case (state)
      ST_RUN:   o_run_on = 1'b1;
      ST_CLEAR: o_clr_on = 1'b1;
      default: begin
        o_run_on = 1'b0;
        o_clr_on = 1'b0;
      end
    endcase
  end

`ifdef UPCNT_CMD_ECHO_EN
  // ---------------- echo buffer ----------------
  logic       echo_vld;
  logic [7:0] echo_data;
  logic [7:0] echo_byte;
  logic       known;

  assign known = (pend_lc == CMD_RUN)
               | (pend_lc == CMD_STOP)
               | (pend_lc == CMD_CLEAR);

  assign echo_byte = known ? (pend_data & 8'hDF) : 8'h3F;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_vld   <= 1'b0;
      echo_data  <= 8'h00;
      o_tx_start <= 1'b0;
      o_tx_data  <= 8'h00;
    end else begin
      o_tx_start <= 1'b0;
      if (echo_vld && !i_tx_busy) begin
        o_tx_start <= 1'b1;
        o_tx_data  <= echo_data;
        echo_vld   <= 1'b0;
      end else if (pend_take && !echo_vld) begin
        echo_vld   <= 1'b1;
        echo_data  <= echo_byte;
      end
    end
  end
`else
  logic unused_tx_busy;

  assign unused_tx_busy = i_tx_busy;
  assign o_tx_start     = 1'b0;
  assign o_tx_data      = 8'h00;
`endif

endmodule

// File: tb/tb_upcnt_cmd_arbiter.sv
// tb_upcnt_cmd_arbiter: directed bench for upcnt_cmd_arbiter.
// Define UPCNT_CMD_ECHO_EN to also check the echo path.

module tb_upcnt_cmd_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_run;
  logic       btn_clr;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_busy;
  logic       run_on;
  logic       clr_on;
  logic       overrun;
  logic [7:0] tx_data;
  logic       tx_start;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  upcnt_cmd_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .i_btn_run_stop (btn_run),
    .i_btn_clear    (btn_clr),
    .i_rx_data      (rx_data),
    .i_rx_done      (rx_done),
    .i_tx_busy      (tx_busy),
    .o_run_on       (run_on),
    .o_clr_on       (clr_on),
    .o_overrun      (overrun),
    .o_tx_data      (tx_data),
    .o_tx_start     (tx_start)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         pulses;
  logic [7:0] sent;
  int         exp_pulses;

  initial begin
    reset   = 1'b0;
    btn_run = 1'b0;
    btn_clr = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_busy = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_run", run_on, 0);
    chk("rst_clr", clr_on, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_txs", tx_start, 0);
    chk("rst_txd", tx_data, 0);
    reset = 1'b1;
    tick();

    // run/stop button: one event per rise
    btn_run = 1'b1;
    tick();
    chk("run_rise", run_on, 1);
    repeat (9) tick();
    chk("run_held", run_on, 1);
    btn_run = 1'b0;
    tick();
    btn_run = 1'b1;
    tick();
    chk("run_2nd", run_on, 0);
    btn_run = 1'b0;
    tick();

    // uppercase 'C' from UART: clear for 4 cycles
    rx_data = 8'h43;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    chk("clr_n1", clr_on, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("clr_hold", clr_on, 1);
      chk("clr_norun", run_on, 0);
      tick();
    end
    chk("clr_end", clr_on, 0);
    chk("clr_end_run", run_on, 0);

    // clear button ignored in RUN, then 's' stops
    btn_run = 1'b1;
    tick();
    btn_run = 1'b0;
    chk("run3", run_on, 1);
    btn_clr = 1'b1;
    tick();
    chk("runclr_run", run_on, 1);
    chk("runclr_clr", clr_on, 0);
    btn_clr = 1'b0;
    tick();
    chk("runclr_clr2", clr_on, 0);
    rx_data = 8'h73;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    chk("stop_n1", run_on, 1);
    tick();
    chk("stop_cmd", run_on, 0);

    // button beats pending 'c'; 'c' then ignored in RUN
    rx_data = 8'h63;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    btn_run = 1'b1;
    tick();
    chk("btn_prio_run", run_on, 1);
    chk("btn_prio_clr", clr_on, 0);
    repeat (5) begin
      tick();
      chk("pend_c_ign", clr_on, 0);
    end
    chk("pend_c_run", run_on, 1);
    btn_run = 1'b0;
    tick();
    btn_run = 1'b1;
    tick();
    chk("back_stop", run_on, 0);
    btn_run = 1'b0;
    tick();

    // overrun: 'r' overwritten by 's' while button blocks
    rx_data = 8'h72;
    rx_done = 1'b1;
    tick();
    rx_data = 8'h73;
    btn_run = 1'b1;
    chk("ovr_pre", overrun, 0);
    tick();
    rx_done = 1'b0;
    chk("ovr_pulse", overrun, 1);
    chk("ovr_run", run_on, 1);
    tick();
    chk("ovr_once", overrun, 0);
    chk("ovr_final", run_on, 0);
    btn_run = 1'b0;
    tick();

    // both buttons rise: clear wins; run press during CLEAR dropped
    btn_run = 1'b1;
    btn_clr = 1'b1;
    tick();
    chk("both_clr", clr_on, 1);
    chk("both_run", run_on, 0);
    btn_run = 1'b0;
    btn_clr = 1'b0;
    tick();
    btn_run = 1'b1;
    tick();
    btn_run = 1'b0;
    tick();
    chk("both_last", clr_on, 1);
    tick();
    chk("both_end_clr", clr_on, 0);
    chk("both_end_run", run_on, 0);
    repeat (3) tick();

    // echo while transmitter busy
    tx_busy = 1'b1;
    rx_data = 8'h72;
    rx_done = 1'b1;
    tick();
    rx_data = 8'h78;
    pulses  = (tx_start === 1'b1) ? 1 : 0;
    tick();
    rx_done = 1'b0;
    repeat (4) begin
      tick();
      if (tx_start === 1'b1) pulses++;
    end
    chk("echo_busy", 8'(pulses), 0);
    tx_busy = 1'b0;
    sent    = 8'h00;
    repeat (5) begin
      tick();
      if (tx_start === 1'b1) begin
        pulses++;
        sent = tx_data;
      end
    end
`ifdef UPCNT_CMD_ECHO_EN
    exp_pulses = 1;
    chk("echo_data", sent, 8'h52);
`else
    exp_pulses = 0;
`endif
    chk("echo_cnt", 8'(pulses), 8'(exp_pulses));
    chk("echo_run", run_on, 1);

    // reset mid-operation with pending 'c'
    rx_data = 8'h63;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_run", run_on, 0);
    chk("mid_rst_clr", clr_on, 0);
    chk("mid_rst_txs", tx_start, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    pulses = 0;
    repeat (3) begin
      tick();
      if (tx_start === 1'b1) pulses++;
    end
    chk("post_rst_clr", clr_on, 0);
    chk("post_rst_run", run_on, 0);
    chk("post_rst_tx", 8'(pulses), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
